// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 16-line request encoder.
package irq_pkg;

   localparam int NREQ = 16;
   localparam int AW   = 4;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   function automatic logic [NREQ-1:0] onehot16(input logic [AW-1:0] idx);
      logic [NREQ-1:0] w_oh;
      w_oh      = {NREQ{1'b0}};
      w_oh[idx] = 1'b1;
      return w_oh;
   endfunction

endpackage

// File: rtl/prio_enc16.sv
// 16-to-4 priority encoder (148-style): index of the highest set bit plus an any flag.
module prio_enc16
   import irq_pkg::*;
(
   input  logic [NREQ-1:0] i_sel,
   output logic [AW-1:0]   o_idx,
   output logic            o_any
);

   // Ascending scan so the highest set index is the last one written.
   always_comb begin
      o_idx = {AW{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         o_idx = i_sel[i] ? AW'(i) : o_idx;
      end
   end

   assign o_any = |i_sel;

endmodule

// File: rtl/irq_encoder16.sv
// Sequential 16-line request encoder with valid/ack handshake.
// Define IRQ_SYNC_EN to pass req_n through a two-flop synchronizer before edge detection.
module irq_encoder16
   import irq_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req_n,
   input  logic [NREQ-1:0] mask,
   output logic [AW-1:0]   code,
   output logic            valid,
   input  logic            ack,
   output logic            gs_n
);

   logic [NREQ-1:0] w_s;
   logic [NREQ-1:0] w_fall;
   logic [NREQ-1:0] w_sel;
   logic [NREQ-1:0] w_clr;
   logic [NREQ-1:0] r_last;
   logic [NREQ-1:0] r_pending;
   logic [AW-1:0]   w_idx;
   logic            w_any;
   state_t          r_state;
   state_t          w_state_nxt;
   logic [AW-1:0]   r_code;
   logic [AW-1:0]   w_code_nxt;
   logic            r_valid;
   logic            w_valid_nxt;

`ifdef IRQ_SYNC_EN
   logic [NREQ-1:0] r_sync1;
   logic [NREQ-1:0] r_sync2;

   // Two-stage synchronizer; idle-high so reset never fakes a falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= {NREQ{1'b1}};
         r_sync2 <= {NREQ{1'b1}};
      end else begin
         r_sync1 <= req_n;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = r_sync2;
`else
   assign w_s = req_n;
`endif

   // History resets high so a line already low after reset is captured exactly once.
   assign w_fall = r_last & ~w_s;
   assign w_sel  = r_pending & ~mask;
   assign gs_n   = ~w_any;

   prio_enc16 u_prio (
      .i_sel (w_sel),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   // Next-state, presented code and clear mask for the handshake.
   always_comb begin
      w_state_nxt = r_state;
      w_code_nxt  = r_code;
      w_valid_nxt = r_valid;
      w_clr       = {NREQ{1'b0}};
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = PRESENT;
               w_code_nxt  = w_idx;
               w_valid_nxt = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         PRESENT: begin
            if (ack) begin
               w_clr       = onehot16(r_code);
               w_valid_nxt = 1'b0;
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = PRESENT;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   // Edge history, pending events (new edge beats a same-cycle clear) and FSM registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last    <= {NREQ{1'b1}};
         r_pending <= {NREQ{1'b0}};
         r_state   <= IDLE;
         r_code    <= {AW{1'b0}};
         r_valid   <= 1'b0;
      end else begin
         r_last    <= w_s;
         r_pending <= (r_pending & ~w_clr) | w_fall;
         r_state   <= w_state_nxt;
         r_code    <= w_code_nxt;
         r_valid   <= w_valid_nxt;
      end
   end

   assign code  = r_code;
   assign valid = r_valid;

endmodule
